// File: rtl/hdmi_fetch_pkg.sv
// Shared types and helpers for the HDMI line fetch controller: state
// enumeration, default widths and a ceiling-divide helper.
package hdmi_fetch_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_FIFO_DEPTH  = 128;
  localparam int DEF_LEVEL_W     = 8;
  localparam int DEF_BURST_WORDS = 32;
  localparam int DEF_WORD_BYTES  = 4;
  localparam int DEF_LEN_W       = 6;
  localparam int DEF_LINES_W     = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    FRAME_INIT,
    LINE_INIT,
    WAIT_SPACE,
    ISSUE,
    WAIT_DONE,
    LINE_END
  } fetch_state_e;

  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    logic [63:0] q;
    q = num / den;
    if (q * den != num) q = q + 64'd1;
    return q;
  endfunction

endpackage

// File: rtl/fetch_space_calc.sv
// Burst sizing for the line fetcher: clamps the remaining line words to one
// burst and reports whether the pixel FIFO has room for that burst.
module fetch_space_calc #(
  parameter int ADDR_W      = 32,
  parameter int FIFO_DEPTH  = 128,
  parameter int LEVEL_W     = 8,
  parameter int BURST_WORDS = 32,
  parameter int LEN_W       = 6
) (
  input  logic [ADDR_W-1:0]  words_left,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic [LEN_W-1:0]   len,
  output logic               space_ok
);

  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_WORDS);

  always_comb begin
    len = LEN_W'(BURST_WORDS);
    if (words_left < BURST_A) len = LEN_W'(words_left);
    // level + len <= depth avoids negative free space when level overshoots
    space_ok = (32'(fifo_level) + 32'(len)) <= 32'(FIFO_DEPTH);
  end

endmodule

// File: rtl/line_fetch_ctrl.sv
// DDR read-burst request generator that keeps the HDMI pixel FIFO fed one
// scanline at a time. Optional macro LINE_FETCH_DOUBLE_LINE_EN fetches each source line twice.
module line_fetch_ctrl
  import hdmi_fetch_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int BURST_WORDS = DEF_BURST_WORDS,
  parameter int WORD_BYTES  = DEF_WORD_BYTES,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int LINES_W     = DEF_LINES_W
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Reset,
  input  logic               enable,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  FRAME_BASE_ADDR,
  input  logic [ADDR_W-1:0]  LINE_STRIDE,
  input  logic [15:0]        NUM_PIXELS_PER_LINE,
  input  logic [2:0]         NUM_BYTES_PER_PIXEL,
  input  logic [LINES_W-1:0] NUM_LINES,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [LEN_W-1:0]   rd_len,
  input  logic               rd_ack,
  input  logic               rd_done,
  output logic               busy,
  output logic               frame_done
);

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]  line_addr;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  stride_q;
  logic [ADDR_W-1:0]  line_words;
  logic [ADDR_W-1:0]  words_left;
  logic [LINES_W-1:0] line_cnt;
  logic [LINES_W-1:0] num_lines_q;
  logic               abort_pend;
  logic               frame_done_q;
`ifdef LINE_FETCH_DOUBLE_LINE_EN
  logic               pass_q;
`endif

  logic [LEN_W-1:0]   len;
  logic               space_ok;
  logic [ADDR_W-1:0]  line_bytes;
  logic [ADDR_W-1:0]  line_words_calc;
  logic [LINES_W-1:0] line_cnt_inc;
  logic               abort_now;
  logic               drop_run;
  logic               last_line;
  logic               burst_last;

  fetch_space_calc #(
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LEVEL_W     (LEVEL_W),
    .BURST_WORDS (BURST_WORDS),
    .LEN_W       (LEN_W)
  ) u_space (
    .words_left (words_left),
    .fifo_level (fifo_level),
    .len        (len),
    .space_ok   (space_ok)
  );

  always_comb begin
    line_bytes      = ADDR_W'(NUM_PIXELS_PER_LINE) * ADDR_W'(NUM_BYTES_PER_PIXEL);
    line_words_calc = ADDR_W'(ceil_div(64'(line_bytes), 64'(WORD_BYTES)));
    line_cnt_inc    = line_cnt + LINES_W'(1);
    last_line       = line_cnt_inc >= num_lines_q;
    burst_last      = words_left <= ADDR_W'(len);
    abort_now       = abort_pend | frame_start;
    drop_run        = !enable;
  end

  // Aborts and disables are only taken when no burst is outstanding
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (enable) state_nxt = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!enable)          state_nxt = IDLE;
        else if (frame_start) state_nxt = FRAME_INIT;
      end
      FRAME_INIT: begin
        if (drop_run)       state_nxt = IDLE;
        else if (abort_now) state_nxt = FRAME_INIT;
        else                state_nxt = LINE_INIT;
      end
      LINE_INIT: begin
        if (drop_run)                 state_nxt = IDLE;
        else if (abort_now)           state_nxt = FRAME_INIT;
        else if (line_words == '0)    state_nxt = LINE_END;
        else                          state_nxt = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (drop_run)       state_nxt = IDLE;
        else if (abort_now) state_nxt = FRAME_INIT;
        else if (space_ok)  state_nxt = ISSUE;
      end
      ISSUE:      if (rd_ack) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (rd_done) begin
          if (drop_run)        state_nxt = IDLE;
          else if (abort_now)  state_nxt = FRAME_INIT;
          else if (burst_last) state_nxt = LINE_END;
          else                 state_nxt = WAIT_SPACE;
        end
      end
      LINE_END: begin
        if (drop_run)       state_nxt = IDLE;
        else if (abort_now) state_nxt = FRAME_INIT;
        else if (last_line) state_nxt = WAIT_FRAME;
        else                state_nxt = LINE_INIT;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state        <= IDLE;
      line_addr    <= '0;
      cur_addr     <= '0;
      stride_q     <= '0;
      line_words   <= '0;
      words_left   <= '0;
      line_cnt     <= '0;
      num_lines_q  <= '0;
      abort_pend   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LINE_FETCH_DOUBLE_LINE_EN
      pass_q       <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      frame_done_q <= (state == LINE_END) && !drop_run && !abort_now && last_line;
      if (state_nxt == FRAME_INIT || state_nxt == IDLE || state_nxt == WAIT_FRAME)
        abort_pend <= 1'b0;
      else
        abort_pend <= abort_now;

      case (state)
        FRAME_INIT: begin
          line_addr   <= FRAME_BASE_ADDR;
          stride_q    <= LINE_STRIDE;
          line_words  <= line_words_calc;
          num_lines_q <= NUM_LINES;
          line_cnt    <= '0;
`ifdef LINE_FETCH_DOUBLE_LINE_EN
          pass_q      <= 1'b0;
`endif
        end
        LINE_INIT: begin
          cur_addr   <= line_addr;
          words_left <= line_words;
        end
        WAIT_DONE: begin
          if (rd_done) begin
            cur_addr   <= cur_addr + ADDR_W'(len) * ADDR_W'(WORD_BYTES);
            words_left <= words_left - ADDR_W'(len);
          end
        end
        LINE_END: begin
          line_cnt <= line_cnt_inc;
`ifdef LINE_FETCH_DOUBLE_LINE_EN
          pass_q <= !pass_q;
          if (pass_q) line_addr <= line_addr + stride_q;
`else
          line_addr <= line_addr + stride_q;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_req     = (state == ISSUE);
    rd_addr    = rd_req ? cur_addr : '0;
    rd_len     = rd_req ? len : '0;
    busy       = !(state == IDLE || state == WAIT_FRAME);
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Self-checking bench for line_fetch_ctrl: a burst-list model of each frame,
// a randomized read-engine responder and a per-cycle compare process.
module tb_line_fetch_ctrl;
  import hdmi_fetch_pkg::*;

  localparam int ADDR_W = 32, FIFO_DEPTH = 128, LEVEL_W = 8, BURST_WORDS = 32;
  localparam int WORD_BYTES = 4, LEN_W = 6, LINES_W = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable, frame_start;
  logic [ADDR_W-1:0]  base_addr, stride;
  logic [15:0]        pixels;
  logic [2:0]         bpp;
  logic [LINES_W-1:0] lines;
  logic [LEVEL_W-1:0] fifo_level;
  logic               rd_req, rd_ack, rd_done, busy, frame_done;
  logic [ADDR_W-1:0]  rd_addr;
  logic [LEN_W-1:0]   rd_len;

  always #5 clk = ~clk;

  line_fetch_ctrl dut (
    .Bus2IP_Clk          (clk),
    .Bus2IP_Reset        (rst),
    .enable              (enable),
    .frame_start         (frame_start),
    .FRAME_BASE_ADDR     (base_addr),
    .LINE_STRIDE         (stride),
    .NUM_PIXELS_PER_LINE (pixels),
    .NUM_BYTES_PER_PIXEL (bpp),
    .NUM_LINES           (lines),
    .fifo_level          (fifo_level),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .rd_len              (rd_len),
    .rd_ack              (rd_ack),
    .rd_done             (rd_done),
    .busy                (busy),
    .frame_done          (frame_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
  } burst_t;

  burst_t exp_q[$];
  burst_t log_q[$];
  int total = 0, bad = 0;
  int done_cnt = 0;
  bit outstanding = 0;
  bit rand_lvl = 0;
  int ack_lo = 0, ack_hi = 0, done_lo = 0, done_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected bursts for a whole frame, straight from the line/burst rules
  function automatic void build_frame(input logic [31:0] b, input logic [31:0] s,
                                      input int px, input int bp, input int nl);
    logic [31:0] a;
    int words, n;
    burst_t e;
    exp_q.delete();
    for (int l = 0; l < nl; l++) begin
      a = b + 32'(l) * s;
      words = (px * bp + WORD_BYTES - 1) / WORD_BYTES;
      while (words > 0) begin
        n = (words > BURST_WORDS) ? BURST_WORDS : words;
        e.addr = a;
        e.len = 32'(n);
        exp_q.push_back(e);
        a = a + 32'(n * WORD_BYTES);
        words -= n;
      end
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_lvl) fifo_level = LEVEL_W'($urandom_range(0, FIFO_DEPTH));
    end
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [31:0] s,
                             input int px, input int bp, input int nl);
    base_addr = b;
    stride = s;
    pixels = 16'(px);
    bpp = 3'(bp);
    lines = LINES_W'(nl);
    build_frame(b, s, px, bp, nl);
    log_q.delete();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      cyc(1);
      n++;
    end
    cyc(4);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 1);
    check({name, "_all_bursts"}, 64'(exp_q.size()), 0);
  endtask

  task automatic wait_bursts(input int cnt, input int budget);
    int n;
    n = 0;
    while (log_q.size() < cnt && n < budget) begin
      cyc(1);
      n++;
    end
    check("burst_wait", 64'(log_q.size()), 64'(cnt));
  endtask

  // Read engine model: randomized ack and done latencies
  initial begin
    int phase, cnt, ad, dd;
    phase = 0; cnt = 0; ad = 0; dd = 0;
    rd_ack = 1'b0;
    rd_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ack = 1'b0;
      rd_done = 1'b0;
      if (rst) begin
        phase = 0;
        cnt = 0;
      end else if (phase == 0) begin
        if (rd_req) begin
          ad = $urandom_range(ack_hi, ack_lo);
          dd = $urandom_range(done_hi, done_lo);
          cnt = 0;
          if (ad == 0) begin rd_ack = 1'b1; phase = 1; end
          else begin cnt = 1; phase = 2; end
        end
      end else if (phase == 2) begin
        if (cnt >= ad) begin rd_ack = 1'b1; phase = 1; cnt = 0; end
        else cnt++;
      end else begin
        if (cnt >= dd) begin rd_done = 1'b1; phase = 0; cnt = 0; end
        else cnt++;
      end
    end
  end

  // Per-cycle compare against the burst model and the handshake rules
  initial begin
    logic p_req, p_ack;
    logic [31:0] p_addr;
    logic [LEN_W-1:0] p_len;
    logic [LEVEL_W-1:0] p_lvl;
    burst_t e, got;
    p_req = 0; p_ack = 0; p_addr = 0; p_len = 0; p_lvl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_req = 0;
        p_ack = 0;
        outstanding = 0;
        continue;
      end
      check("one_outstanding", 64'(rd_req & outstanding), 0);
      if (p_req && !p_ack) begin
        check("req_hold", 64'(rd_req), 1);
        check("addr_hold", 64'(rd_addr), 64'(p_addr));
        check("len_hold", 64'(rd_len), 64'(p_len));
      end
      if (rd_req && !p_req && exp_q.size() > 0)
        check("space_at_issue", 64'((FIFO_DEPTH - int'(p_lvl)) >= int'(exp_q[0].len)), 1);
      if (rd_req && rd_ack) begin
        got.addr = rd_addr;
        got.len = 32'(rd_len);
        log_q.push_back(got);
        outstanding = 1;
        check("burst_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("burst_addr", 64'(rd_addr), 64'(e.addr));
          check("burst_len", 64'(rd_len), 64'(e.len));
        end
      end
      if (rd_done) outstanding = 0;
      if (frame_done) begin
        done_cnt++;
        check("done_after_last_burst", 64'(exp_q.size()), 0);
        check("done_busy_low", 64'(busy), 0);
      end
      p_req = rd_req;
      p_ack = rd_ack;
      p_addr = rd_addr;
      p_len = rd_len;
      p_lvl = fifo_level;
    end
  end

  initial begin
    int d0;
    rst = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    base_addr = '0;
    stride = '0;
    pixels = '0;
    bpp = '0;
    lines = '0;
    fifo_level = '0;
    cyc(3);
    check("rst_rd_req", 64'(rd_req), 0);
    check("rst_rd_addr", 64'(rd_addr), 0);
    check("rst_rd_len", 64'(rd_len), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_frame_done", 64'(frame_done), 0);
    check("rst_state", 64'(dut.state == IDLE), 1);
    rst = 1'b0;
    enable = 1'b1;
    cyc(2);
    check("armed_busy", 64'(busy), 0);

    // Basic frame: 640 px x 4 B, two lines, immediate ack/done
    ack_lo = 0; ack_hi = 0; done_lo = 0; done_hi = 0;
    start_frame(32'h1000_0000, 32'd2560, 640, 4, 2);
    check("model_basic_count", 64'(exp_q.size()), 40);
    cyc(1);
    check("basic_busy", 64'(busy), 1);
    wait_frame("basic", 2000);
    check("basic_log_count", 64'(log_q.size()), 40);
    if (log_q.size() == 40) begin
      check("basic_first_addr", 64'(log_q[0].addr), 64'h1000_0000);
      check("basic_line1_addr", 64'(log_q[20].addr), 64'h1000_0A00);
      check("basic_len", 64'(log_q[19].len), 32);
    end

    // Short final burst: 100 px x 3 B = 75 words
    start_frame(32'h2000_0000, 32'd512, 100, 3, 1);
    check("model_short_count", 64'(exp_q.size()), 3);
    wait_frame("short", 500);
    check("short_log_count", 64'(log_q.size()), 3);
    if (log_q.size() == 3) begin
      check("short_len0", 64'(log_q[0].len), 32);
      check("short_len2", 64'(log_q[2].len), 11);
      check("short_addr2", 64'(log_q[2].addr), 64'h2000_0100);
    end

    // Flow control: 28 words free stalls a 32-word burst
    fifo_level = 8'd100;
    start_frame(32'h3000_0000, 32'd256, 64, 4, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("stall_req", 64'(rd_req), 0);
    end
    fifo_level = 8'd96;
    cyc(1);
    check("req_after_space", 64'(rd_req), 1);
    fifo_level = '0;
    wait_frame("flow", 500);

    // Handshake hold: ack delayed five cycles
    ack_lo = 5; ack_hi = 5; done_lo = 0; done_hi = 2;
    start_frame(32'h3100_0040, 32'd256, 64, 4, 1);
    wait_frame("hold", 500);
    check("hold_accepts", 64'(log_q.size()), 2);

    // Abort during WAIT_DONE of line 3
    ack_lo = 0; ack_hi = 2; done_lo = 4; done_hi = 4;
    start_frame(32'h4000_0000, 32'h100, 16, 4, 6);
    wait_bursts(4, 300);
    check("abort_line3_addr", 64'(dut.rd_addr == 0 && log_q.size() == 4 ? log_q[3].addr : 0), 64'h4000_0300);
    build_frame(32'h4000_0000, 32'h100, 16, 4, 6);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    wait_frame("abort", 1000);
    check("abort_log_count", 64'(log_q.size()), 10);
    if (log_q.size() == 10)
      check("abort_restart_addr", 64'(log_q[4].addr), 64'h4000_0000);

    // Enable dropped mid-frame: drain, then idle with no frame_done
    ack_lo = 0; ack_hi = 1; done_lo = 3; done_hi = 3;
    start_frame(32'h5000_0000, 32'h200, 16, 4, 4);
    wait_bursts(2, 300);
    d0 = done_cnt;
    enable = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 40 && busy; n++) cyc(1);
    cyc(3);
    check("disable_busy", 64'(busy), 0);
    check("disable_state", 64'(dut.state == IDLE), 1);
    check("disable_no_done", 64'(done_cnt - d0), 0);
    check("disable_no_more_bursts", 64'(log_q.size()), 2);
    enable = 1'b1;
    cyc(2);

    // Randomized frames with a fluctuating FIFO level
    ack_lo = 0; ack_hi = 3; done_lo = 0; done_hi = 3;
    rand_lvl = 1;
    for (int f = 0; f < 8; f++) begin
      start_frame($urandom, $urandom_range(0, 32'hFFFF_FFFF), $urandom_range(0, 300),
                  $urandom_range(1, 4), $urandom_range(1, 4));
      wait_frame("random", 8000);
    end
    rand_lvl = 0;
    fifo_level = '0;
    cyc(2);

    // Reset asserted while a request is pending
    ack_lo = 8; ack_hi = 8; done_lo = 0; done_hi = 0;
    start_frame(32'h6000_0000, 32'h100, 64, 4, 2);
    for (int n = 0; n < 50 && !rd_req; n++) cyc(1);
    check("reset_pending_req", 64'(rd_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", 64'(rd_req), 0);
    check("async_rst_busy", 64'(busy), 0);
    check("async_rst_done", 64'(frame_done), 0);
    check("async_rst_state", 64'(dut.state == IDLE), 1);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check("post_rst_busy", 64'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_fetch_ctrl.md
Name: line_fetch_ctrl

Overview:
- Parametrised successor to the HDMI-out FIFO fill FSM.
- Generates DDR read-burst requests (address + length) that keep the pixel FIFO fed, one scanline at a time, across a full frame.
- Sits in hdmi_out user_logic between the slv_reg software registers, the hdmi_core sync pulses, the pixel FIFO level and the bus-master read engine.
- New versus the predecessor: configurable burst and FIFO sizes, space-based (credit) flow control, a short final burst per line, a line counter, a proper req/ack/done handshake and frame abort.

Parameters:
- ADDR_W, 32, width of address and stride registers.
- FIFO_DEPTH, 128, pixel FIFO depth in words.
- LEVEL_W, 8, width of fifo_level; must satisfy 2^LEVEL_W > FIFO_DEPTH.
- BURST_WORDS, 32, maximum burst length in words; must be ≤ FIFO_DEPTH.
- WORD_BYTES, 4, bytes per FIFO word.
- LEN_W, 6, width of rd_len; must hold BURST_WORDS.
- LINES_W, 12, width of the line counter.

Ports:
- Bus2IP_Clk  in  1  clock.
- Bus2IP_Reset  in  1  asynchronous, active-high reset.
- enable  in  1  software run bit; level-sensitive.
- frame_start  in  1  one-cycle pulse marking the start of the frame (derived from vsync).
- FRAME_BASE_ADDR  in  ADDR_W  byte address of line 0.
- LINE_STRIDE  in  ADDR_W  byte distance between line starts.
- NUM_PIXELS_PER_LINE  in  16  pixels per line.
- NUM_BYTES_PER_PIXEL  in  3  bytes per pixel, 1..4.
- NUM_LINES  in  LINES_W  lines per frame.
- fifo_level  in  LEVEL_W  words currently held in the FIFO.
- rd_req  out  1  burst request.
- rd_addr  out  ADDR_W  burst byte address.
- rd_len  out  LEN_W  burst length in words.
- rd_ack  in  1  read engine accepted the request.
- rd_done  in  1  last word of the burst has been written into the FIFO.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last burst of the last line.

Behaviour:
- Reset values: every output 0; state IDLE; all internal counters 0.
- Parameter sampling: FRAME_BASE_ADDR, LINE_STRIDE, pixel count, bpp and NUM_LINES are sampled only in FRAME_INIT and held for the whole frame.
- IDLE: move to WAIT_FRAME when enable=1.
- WAIT_FRAME:
  - Move to FRAME_INIT on frame_start.
  - Return to IDLE if enable=0.
- FRAME_INIT (1 cycle):
  - line_addr = FRAME_BASE_ADDR; line_cnt = 0.
  - line_words = ceil(pixels*bpp / WORD_BYTES), computed in ADDR_W-bit arithmetic and truncated.
  - busy = 1.
- LINE_INIT (1 cycle):
  - cur_addr = line_addr; words_left = line_words.
  - If line_words = 0, go directly to LINE_END.
- WAIT_SPACE:
  - len = min(BURST_WORDS, words_left).
  - Move to ISSUE when FIFO_DEPTH − fifo_level ≥ len.
- ISSUE:
  - rd_req = 1 with rd_addr/rd_len stable until rd_ack.
  - rd_req and rd_ack both high in the same cycle completes the handshake; move to WAIT_DONE.
- WAIT_DONE:
  - On rd_done: cur_addr += len*WORD_BYTES; words_left −= len.
  - If words_left becomes 0, go to LINE_END; otherwise go to WAIT_SPACE.
  - Exactly one burst is outstanding at any time.
- LINE_END:
  - line_addr += LINE_STRIDE; line_cnt += 1.
  - If line_cnt reaches NUM_LINES: pulse frame_done, clear busy, return to WAIT_FRAME.
  - Otherwise go to LINE_INIT.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- frame_start while busy:
  - If a burst is outstanding (ISSUE or WAIT_DONE), finish that burst (ack, then done) first.
  - Then go to FRAME_INIT. No frame_done pulse for the aborted frame.
- enable falling while busy:
  - Same drain rule as frame abort, then go to IDLE.
  - busy clears after the drain.
- Simultaneous rd_done and frame_start: rd_done is accounted first, then the abort is taken.
- Reset asserted mid-burst: outputs clear immediately. The read engine must tolerate a dropped rd_req.

Optional Feature:
- Macro: LINE_FETCH_DOUBLE_LINE_EN.
- Defined: each source line is fetched twice (vertical 2x scaling).
  - LINE_END advances line_addr by LINE_STRIDE only on every second pass.
  - line_cnt still counts output lines, so NUM_LINES is the output height.
- Undefined: one fetch per line; the repeat-pass logic is absent.

Decomposition:
- Shared package hdmi_fetch_pkg holds:
  - the state enumeration (IDLE, WAIT_FRAME, FRAME_INIT, LINE_INIT, WAIT_SPACE, ISSUE, WAIT_DONE, LINE_END);
  - default widths;
  - a ceil-divide helper function.
- One sub-module, fetch_space_calc: combinational min(BURST_WORDS, words_left) plus the space-available compare, giving len and space_ok.

Test Plan:
- Basic frame: base=0x1000_0000, stride=2560, 640 px, 4 B, 2 lines, fifo_level=0, ack/done immediate.
  - 20 bursts of 32 words per line.
  - Line 1 starts at 0x1000_0A00.
  - frame_done pulses once.
- Short final burst: 100 px, 3 B → 75 words.
  - Bursts of 32, 32, 11.
  - Third rd_addr = base+256.
- Flow control: fifo_level=100, FIFO_DEPTH=128.
  - rd_req stays 0.
  - Drop level to 96 → rd_req asserts the next cycle.
- Handshake hold: rd_ack delayed 5 cycles → rd_addr/rd_len remain stable throughout; exactly one request is accepted.
- Abort: frame_start during WAIT_DONE of line 3.
  - After rd_done, the next rd_addr = FRAME_BASE_ADDR.
  - No frame_done pulse.
- Reset mid-ISSUE: Bus2IP_Reset asserted asynchronously → rd_req, busy and frame_done are 0 before the next clock edge; state is IDLE.
